order_cmd_dispatcher: RTL

Upstream feeder for the binary-tree order book. It accepts decoded order commands (add / cancel / execute) from the message parser on a valid/ready stream and buffers them in a small FIFO. It sanity-filters each command and issues exactly one command at a time to the book. Each issue is a single-cycle start_book pulse, and the dispatcher then paces itself on the book's busy and price_valid outputs so the price tree has settled before the next command.

---
 rtl/book_pkg.sv | 50 +++++
 rtl/order_cmd_dispatcher_cmd_fifo.sv | 56 +++++
 rtl/order_cmd_dispatcher.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/book_pkg.sv
// Shared definitions for the order book and its command dispatcher.
//   - request codes (ADD_ORDER / CANCEL_ORDER / EXECUTE_ORDER)
//   - field widths (PRICE_INDEX, QUANTITY_INDEX, ORDER_INDEX are MSB indices)
//   - book_entry : payload the book stores for an ADD
//   - book_cmd   : one decoded parser command, also the dispatcher FIFO word
//   - disp_state_e : dispatcher FSM states
//   - cmd_is_legal : sanity filter applied before a command is queued
package book_pkg;

   localparam int PRICE_INDEX    = 7;
   localparam int QUANTITY_INDEX = 15;
   localparam int ORDER_INDEX    = 7;

   localparam logic [2:0] ADD_ORDER     = 3'd1;
   localparam logic [2:0] CANCEL_ORDER  = 3'd2;
   localparam logic [2:0] EXECUTE_ORDER = 3'd3;

   typedef struct packed {
      logic [ORDER_INDEX:0]    order_id;
      logic [PRICE_INDEX:0]    price;
      logic [QUANTITY_INDEX:0] quantity;
   } book_entry;

   typedef struct packed {
      logic [2:0]              cmd_type;
      logic [ORDER_INDEX:0]    order_id;
      logic [PRICE_INDEX:0]    price;
      logic [QUANTITY_INDEX:0] quantity;
   } book_cmd;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } disp_state_e;

   // CANCEL carries no meaningful price/quantity, so it is always legal.
   function automatic logic cmd_is_legal(input book_cmd c, input logic [PRICE_INDEX:0] max_price);
      logic ok;
      ok = 1'b0;
      case (c.cmd_type)
         ADD_ORDER:     ok = (c.quantity != '0) && (c.price <= max_price);
         CANCEL_ORDER:  ok = 1'b1;
         EXECUTE_ORDER: ok = (c.quantity != '0);
         default:       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/order_cmd_dispatcher_cmd_fifo.sv
// cmd_fifo: single-clock FIFO of book_cmd words with an exact registered level.
//   clk_i, rst_i (async, active-high)
//   push_i/wdata_i : write when not full (a push at full is ignored, even with a pop)
//   pop_i/rdata_o  : rdata_o shows the head; pop_i removes it when not empty
//   level_o        : occupied entries, full_o / empty_o derived from it
module cmd_fifo
   import book_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  book_cmd                wdata_i,
   input  logic                   pop_i,
   output book_cmd                rdata_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q;
   book_cmd       mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full_o  = (level_q == (AW + 1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (do_push && !do_pop)      level_q <= level_q + LVL_ONE;
         else if (do_pop && !do_push) level_q <= level_q - LVL_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/order_cmd_dispatcher.sv
// order_cmd_dispatcher: buffers parser commands and issues them one at a
// time to the order book, pacing on the book's busy / price_valid.
//   clk_in, rst_in (async assert, release synchronised internally)
//   cmd_*          : parser stream; cmd_ready_o = FIFO not full
//   book_busy_i, book_price_valid_i : book status used for pacing
//   start_book_o   : one-cycle issue strobe, request_o + payload alongside
//   order_to_add_o / order_id_o / quantity_o : hold between strobes
//   fifo_level_o, issued_cnt_o, drop_cnt_o : status
// Handshake: a command transfers on a rising clk_in where cmd_valid_i and
// cmd_ready_o are both high; illegal commands still transfer but are
// counted in drop_cnt_o instead of being queued.
module order_cmd_dispatcher
   import book_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int MIN_GAP    = 1,
   parameter int WAIT_PRICE = 1,
   parameter int MAX_PRICE  = 127
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [2:0]              cmd_type_i,
   input  logic [ORDER_INDEX:0]    cmd_order_id_i,
   input  logic [PRICE_INDEX:0]    cmd_price_i,
   input  logic [QUANTITY_INDEX:0] cmd_qty_i,
   input  logic                    book_busy_i,
   input  logic                    book_price_valid_i,
   output logic                    start_book_o,
   output logic [2:0]              request_o,
   output book_entry               order_to_add_o,
   output logic [ORDER_INDEX:0]    order_id_o,
   output logic [QUANTITY_INDEX:0] quantity_o,
   output logic [$clog2(DEPTH):0]  fifo_level_o,
   output logic [15:0]             issued_cnt_o,
   output logic [15:0]             drop_cnt_o
);

   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

   // Reset asserts immediately, deasserts two clocks after rst_in falls.
   logic [1:0] rst_sync_q;
   logic       rst_int;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) rst_sync_q <= 2'b11;
      else        rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_int = rst_sync_q[1];

   disp_state_e             state_q, state_d;
   logic [GW-1:0]           gap_q, gap_d;
   logic                    start_q, start_d;
   logic [2:0]              request_q, request_d;
   book_entry               add_q, add_d;
   logic [ORDER_INDEX:0]    id_q, id_d;
   logic [QUANTITY_INDEX:0] qty_q, qty_d;
   logic [15:0]             issued_q, issued_d;
   logic [15:0]             drop_q, drop_d;

   book_cmd                 in_cmd, head;
   logic                    cmd_accept, cmd_legal, fifo_pop;
   logic                    fifo_full, fifo_empty;

   assign in_cmd      = '{cmd_type: cmd_type_i, order_id: cmd_order_id_i,
                          price: cmd_price_i, quantity: cmd_qty_i};
   assign cmd_legal   = cmd_is_legal(in_cmd, (PRICE_INDEX + 1)'(MAX_PRICE));
   assign cmd_ready_o = !fifo_full && !rst_int;
   assign cmd_accept  = cmd_valid_i && cmd_ready_o;

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_in),
      .rst_i   (rst_int),
      .push_i  (cmd_accept && cmd_legal),
      .wdata_i (in_cmd),
      .pop_i   (fifo_pop),
      .rdata_o (head),
      .level_o (fifo_level_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      start_d   = 1'b0;
      request_d = request_q;
      add_d     = add_q;
      id_d      = id_q;
      qty_d     = qty_q;
      issued_d  = issued_q;
      drop_d    = drop_q;
      fifo_pop  = 1'b0;

      if (cmd_accept && !cmd_legal) drop_d = drop_q + 16'd1;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !book_busy_i && ((WAIT_PRICE == 0) || book_price_valid_i))
               state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            // Only the fields meaningful for this request are updated; the
            // others keep the value from the last command that used them.
            fifo_pop  = 1'b1;
            start_d   = 1'b1;
            request_d = head.cmd_type;
            case (head.cmd_type)
               ADD_ORDER: add_d = '{order_id: head.order_id, price: head.price,
                                    quantity: head.quantity};
               CANCEL_ORDER: id_d = head.order_id;
               EXECUTE_ORDER: begin
                  id_d  = head.order_id;
                  qty_d = head.quantity;
               end
               default: ;
            endcase
            issued_d = issued_q + 16'd1;
            gap_d    = GW'(MIN_GAP);
            state_d  = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
         end
         ST_GAP: begin
            // Leaving on the last count makes the issue interval 2 + MIN_GAP.
            gap_d = gap_q - GW'(1);
            if (gap_q <= GW'(1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_int) begin
      if (rst_int) begin
         state_q   <= ST_IDLE;
         gap_q     <= '0;
         start_q   <= 1'b0;
         request_q <= '0;
         add_q     <= '0;
         id_q      <= '0;
         qty_q     <= '0;
         issued_q  <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         start_q   <= start_d;
         request_q <= request_d;
         add_q     <= add_d;
         id_q      <= id_d;
         qty_q     <= qty_d;
         issued_q  <= issued_d;
         drop_q    <= drop_d;
      end
   end

   assign start_book_o   = start_q;
   assign request_o      = request_q;
   assign order_to_add_o = add_q;
   assign order_id_o     = id_q;
   assign quantity_o     = qty_q;
   assign issued_cnt_o   = issued_q;
   assign drop_cnt_o     = drop_q;

endmodule
